// File: rtl/rr_stage_arb.sv
// rr_stage_arb: two-requester round-robin arbiter with bounded bursts feeding one registered output stage
module rr_stage_arb #(
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic          busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic free, x0, x1, xfer, burst_done;
  assign free       = !out_valid || out_ready;
  assign req0_ready = (state == GRANT0) && free;
  assign req1_ready = (state == GRANT1) && free;
  assign x0         = req0_valid && req0_ready;
  assign x1         = req1_valid && req1_ready;
  assign xfer       = x0 || x1;
  assign burst_done = xfer && (cnt + 1'b1 == CW'(MAX_BURST));
  assign busy       = state != IDLE;
  // grant selection, release on idle requester or burst limit, burst counting
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = xfer ? cnt + 1'b1 : cnt;
    case (state)
      IDLE: begin
        state_n = (req0_valid && (!req1_valid || last)) ? GRANT0 : req1_valid ? GRANT1 : IDLE;
        cnt_n   = '0;
      end
      GRANT0: if (!req0_valid || burst_done) begin
        last_n  = 1'b0;
        cnt_n   = '0;
        state_n = req1_valid ? GRANT1 : burst_done ? GRANT0 : IDLE;
      end
      GRANT1: if (!req1_valid || burst_done) begin
        last_n  = 1'b1;
        cnt_n   = '0;
        state_n = req0_valid ? GRANT0 : burst_done ? GRANT1 : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // arbiter state and output register; a load wins over a simultaneous drain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= x1 ? req1_data : req0_data;
        out_src   <= x1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
